lpc_tpm_bridge: RTL and testbench
=================================

Name: lpc_tpm_bridge

Overview:
Downstream stage of the LPC peripheral FSM. It takes one decoded TPM/IO cycle (address, direction, write data) and runs a single-access handshake to the TPM register file. While the access is outstanding it asserts busy so the LPC FSM drives SYNC long-wait. It then returns read data, an error (timeout, mapped to SYNC ERROR) or no-response (the LPC FSM leaves LAD floating).

Parameters:
LOC_MAX, 4, highest accepted locality; address bits [15:12] above this are not claimed
TIMEOUT_CYCLES, 64, edges without reg_ack_i before the access is declared failed (range 2..255)

Ports:
lclk_i  input  1  LPC clock; all logic on rising edge
lreset  input  1  asynchronous, active-low reset
abort_i  input  1  LFRAME# abort seen by the LPC FSM; cancels the current access
req_valid_i  input  1  one-cycle pulse: decoded cycle ready
req_write_i  input  1  1 = write, 0 = read
req_addr_i  input  16  low 16 address bits of the TPM cycle
req_wdata_i  input  8  write data
busy_o  output  1  access in progress; LPC FSM sends SYNC long-wait
rsp_valid_o  output  1  one-cycle pulse: response available
rsp_err_o  output  1  qualifies rsp_valid_o: access timed out
rsp_nores_o  output  1  one-cycle pulse: address not claimed
rsp_rdata_o  output  8  read data; held until the next accepted request
reg_req_o  output  1  one-cycle request strobe to the register file
reg_we_o  output  1  write enable, valid with reg_req_o
reg_addr_o  output  16  captured address
reg_wdata_o  output  8  captured write data
reg_ack_i  input  1  register file completion
reg_rdata_i  input  8  read data, valid with reg_ack_i
err_cnt_o  output  8  saturating count of timeouts

Behaviour:
- All outputs are registered (Moore). Reset (lreset=0, async) sets state IDLE and every output/counter to 0.
- States: IDLE, NORESP, ISSUE, WAIT, RESP.
- IDLE: if req_valid_i=1 and abort_i=0 at edge E0, capture write/addr/wdata.
  - If addr[15:12] > LOC_MAX, go to NORESP.
  - Otherwise go to ISSUE and clear the timeout counter.
  - req_valid_i is ignored in every state other than IDLE; there is no queueing.
- NORESP: rsp_nores_o=1 for one cycle, busy_o=0, no reg_req_o. Next state is IDLE.
- ISSUE: reg_req_o=1 for exactly one cycle; reg_we_o, reg_addr_o, reg_wdata_o reflect the captured values; busy_o=1.
- reg_ack_i is sampled at every edge in ISSUE and WAIT.
  - Ack seen: for a read, latch reg_rdata_i into rsp_rdata_o; for a write, load rsp_rdata_o with 0x00. Next state is RESP.
  - No ack: the counter increments. When the counter reaches TIMEOUT_CYCLES, go to RESP with the error flag set and err_cnt_o incremented (saturates at 255).
  - Ack and timeout at the same edge: the ack wins and no error is flagged.
- busy_o=1 in ISSUE, WAIT and RESP.
- RESP: rsp_valid_o=1 for one cycle, with rsp_err_o equal to the error flag. Next state is IDLE. rsp_err_o returns to 0 with rsp_valid_o.
- Latency: the earliest response (ack during ISSUE) gives rsp_valid_o in the 3rd cycle after E0. With no ack, rsp_valid_o/rsp_err_o appear in the cycle after the TIMEOUT_CYCLES-th edge following E0.
- abort_i=1 at any edge in NORESP, ISSUE, WAIT or RESP:
  - next state is IDLE; no rsp_valid_o or rsp_nores_o pulse in the following cycle;
  - busy_o and reg_req_o drop; err_cnt_o is unchanged.
- Stale acks: a pending flag, set in ISSUE and cleared on ack, discards an ack arriving after an abort (ack in IDLE). It does not affect the next access. If a new request is accepted while pending=1, the first reg_ack_i of that access is dropped.
- Reset mid-access: immediate return to IDLE, all outputs 0, err_cnt_o cleared.

Test Plan:
- Read 0x0F00 (locality 0), reg_ack_i at the 2nd WAIT edge with reg_rdata_i=0xA5 -> one reg_req_o pulse with reg_we_o=0 and reg_addr_o=0x0F00; rsp_valid_o=1, rsp_err_o=0, rsp_rdata_o=0xA5; busy_o high from ISSUE through RESP.
- Write 0x0024 data 0x3C, ack during ISSUE -> reg_we_o=1, reg_wdata_o=0x3C; rsp_valid_o in the 3rd cycle after E0 with rsp_rdata_o=0x00.
- Read 0x5000 with LOC_MAX=4 -> single rsp_nores_o pulse; no reg_req_o, busy_o, or rsp_valid_o.
- Read with no ack, TIMEOUT_CYCLES=64 -> rsp_valid_o=1, rsp_err_o=1 in the cycle after the 64th edge; err_cnt_o 0->1. An ack at exactly the 64th edge gives rsp_err_o=0 and err_cnt_o unchanged.
- abort_i at the 3rd WAIT edge, then reg_ack_i 2 cycles later, then a new read acked with 0x11 -> no response for the aborted access; the stale ack is ignored; the new access returns 0x11.
- lreset pulsed low during WAIT -> all outputs 0 immediately; the next request completes normally.

Source files
------------

// File: rtl/lpc_tpm_bridge.sv
// lpc_tpm_bridge: runs one decoded LPC TPM/IO cycle as a single-access
// handshake to the TPM register file, and reports data, timeout error or
// no-response back to the LPC peripheral FSM. Every output is a flop whose
// next value is derived from the next state.
module lpc_tpm_bridge #(
   parameter int unsigned LOC_MAX        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        lclk_i,
   input  logic        lreset,
   input  logic        abort_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [15:0] req_addr_i,
   input  logic [7:0]  req_wdata_i,
   output logic        busy_o,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic        rsp_nores_o,
   output logic [7:0]  rsp_rdata_o,
   output logic        reg_req_o,
   output logic        reg_we_o,
   output logic [15:0] reg_addr_o,
   output logic [7:0]  reg_wdata_o,
   input  logic        reg_ack_i,
   input  logic [7:0]  reg_rdata_i,
   output logic [7:0]  err_cnt_o
);

   // Locality limit clamped to the 4-bit locality field.
   localparam logic [3:0] LOC_LIM = (LOC_MAX > 15) ? 4'd15 : 4'(LOC_MAX);
   localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORESP,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        pending_q, pending_d;   // an issued access is still owed an ack
   logic        stale_q, stale_d;       // first ack of this access belongs to an aborted one
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        nores_q, nores_d;
   logic        timed_out;
   logic        real_ack;

   // State and output registers, cleared asynchronously by lreset.
   always_ff @(posedge lclk_i or negedge lreset) begin
      if (!lreset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         err_cnt_q <= '0;
         pending_q <= 1'b0;
         stale_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         nores_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
         pending_q <= pending_d;
         stale_q   <= stale_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         req_q     <= req_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         nores_q   <= nores_d;
      end
   end

   // Next-state logic, ack/timeout arbitration and registered-output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;
      pending_d = pending_q;
      stale_d   = stale_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      timed_out = 1'b0;
      real_ack  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A late ack from an aborted or timed-out access is absorbed here.
            if (reg_ack_i) pending_d = 1'b0;
            if (req_valid_i && !abort_i) begin
               we_d    = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               if (req_addr_i[15:12] > LOC_LIM) begin
                  state_d = S_NORESP;
               end else begin
                  state_d   = S_ISSUE;
                  cnt_d     = '0;
                  stale_d   = pending_q && !reg_ack_i;
                  pending_d = 1'b1;
               end
            end
         end
         S_NORESP: begin
            if (reg_ack_i) pending_d = 1'b0;
            state_d = S_IDLE;
         end
         S_ISSUE, S_WAIT: begin
            real_ack = reg_ack_i && !stale_q;
            if (reg_ack_i && stale_q) stale_d = 1'b0;
            if (real_ack) pending_d = 1'b0;
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (real_ack) begin
               // The ack wins even on the edge where the timeout would fire.
               state_d = S_RESP;
               rdata_d = we_q ? 8'h00 : reg_rdata_i;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TO_LIM) begin
                  state_d   = S_RESP;
                  timed_out = 1'b1;
                  if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_RESP: begin
            if (reg_ack_i) pending_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_RESP);
      req_d   = (state_d == S_ISSUE);
      valid_d = (state_d == S_RESP);
      err_d   = timed_out;
      nores_d = (state_d == S_NORESP);
   end

   assign busy_o      = busy_q;
   assign rsp_valid_o = valid_q;
   assign rsp_err_o   = err_q;
   assign rsp_nores_o = nores_q;
   assign rsp_rdata_o = rdata_q;
   assign reg_req_o   = req_q;
   assign reg_we_o    = we_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_lpc_tpm_bridge.sv
// tb_lpc_tpm_bridge: directed and randomized transactions against a
// transaction-level model of the bridge. Edge numbering: E0 is the edge that
// accepts the request (its own cycle is the first), E1 is the ISSUE edge, and
// an access ending at edge Ek shows its response in the cycle after Ek.
module tb_lpc_tpm_bridge;

   localparam int LOC_MAX = 4;
   localparam int TO      = 64;

   logic        lclk_i;
   logic        lreset;
   logic        abort_i;
   logic        req_valid_i;
   logic        req_write_i;
   logic [15:0] req_addr_i;
   logic [7:0]  req_wdata_i;
   logic        busy_o;
   logic        rsp_valid_o;
   logic        rsp_err_o;
   logic        rsp_nores_o;
   logic [7:0]  rsp_rdata_o;
   logic        reg_req_o;
   logic        reg_we_o;
   logic [15:0] reg_addr_o;
   logic [7:0]  reg_wdata_o;
   logic        reg_ack_i;
   logic [7:0]  reg_rdata_i;
   logic [7:0]  err_cnt_o;

   lpc_tpm_bridge #(.LOC_MAX(LOC_MAX), .TIMEOUT_CYCLES(TO)) dut (
      .lclk_i      (lclk_i),
      .lreset      (lreset),
      .abort_i     (abort_i),
      .req_valid_i (req_valid_i),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .busy_o      (busy_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_nores_o (rsp_nores_o),
      .rsp_rdata_o (rsp_rdata_o),
      .reg_req_o   (reg_req_o),
      .reg_we_o    (reg_we_o),
      .reg_addr_o  (reg_addr_o),
      .reg_wdata_o (reg_wdata_o),
      .reg_ack_i   (reg_ack_i),
      .reg_rdata_i (reg_rdata_i),
      .err_cnt_o   (err_cnt_o)
   );

   initial lclk_i = 1'b0;
   always #5 lclk_i = ~lclk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   // Reference model state
   logic [7:0]  m_rdata   = 8'h00;
   logic [7:0]  m_errcnt  = 8'h00;
   logic [15:0] m_addr    = 16'h0000;
   logic        m_we      = 1'b0;
   logic [7:0]  m_wdata   = 8'h00;
   bit          m_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string ph, input bit b, input bit r, input bit v,
                             input bit e, input bit n);
      chk({ph, ".busy"},  {31'd0, busy_o},      {31'd0, b});
      chk({ph, ".req"},   {31'd0, reg_req_o},   {31'd0, r});
      chk({ph, ".valid"}, {31'd0, rsp_valid_o}, {31'd0, v});
      chk({ph, ".err"},   {31'd0, rsp_err_o},   {31'd0, e});
      chk({ph, ".nores"}, {31'd0, rsp_nores_o}, {31'd0, n});
      chk({ph, ".rdata"}, {24'd0, rsp_rdata_o}, {24'd0, m_rdata});
      chk({ph, ".errcnt"},{24'd0, err_cnt_o},   {24'd0, m_errcnt});
      chk({ph, ".addr"},  {16'd0, reg_addr_o},  {16'd0, m_addr});
      chk({ph, ".we"},    {31'd0, reg_we_o},    {31'd0, m_we});
      chk({ph, ".wdata"}, {24'd0, reg_wdata_o}, {24'd0, m_wdata});
   endtask

   task automatic tick();
      @(posedge lclk_i);
      #1;
   endtask

   // Idle cycles; an ack pulse may be injected at idle cycle ack_at (-1: none).
   task automatic idle(input int n, input int ack_at);
      for (int i = 0; i < n; i++) begin
         req_valid_i = 1'b0;
         abort_i     = 1'b0;
         reg_ack_i   = (i == ack_at);
         reg_rdata_i = 8'($urandom);
         tick();
         if (i == ack_at) m_pending = 1'b0;
         check_outs("idle", 0, 0, 0, 0, 0);
      end
      reg_ack_i = 1'b0;
   endtask

   // One access. k: edge at which reg_ack_i first rises (0: never).
   // a: edge at which abort_i is raised (0: never).
   task automatic run_txn(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                          input int k, input logic [7:0] ad, input int a);
      bit    claimed;
      bit    stale;
      int    keff;
      int    ev_ack;
      int    ev_ab;
      int    fin;
      int    kind;   // 0 acked, 1 timed out, 2 aborted
      string kname;
      claimed = (addr[15:12] <= LOC_MAX);
      n_txn++;
      req_valid_i = 1'b1;
      req_write_i = we;
      req_addr_i  = addr;
      req_wdata_i = wd;
      abort_i     = 1'b0;
      reg_ack_i   = 1'b0;
      tick();  // E0
      m_addr  = addr;
      m_we    = we;
      m_wdata = wd;
      req_valid_i = 1'b0;
      if (!claimed) begin
         check_outs("nores", 0, 0, 0, 0, 1);
         req_valid_i = 1'($urandom_range(0, 1));
         req_addr_i  = 16'($urandom) & 16'h4FFF;
         tick();
         req_valid_i = 1'b0;
         check_outs("nores_end", 0, 0, 0, 0, 0);
         $display("txn %0d we=%0b addr=%04h -> no response", n_txn, we, addr);
         return;
      end
      stale  = m_pending;
      keff   = (k == 0) ? 0 : k + (stale ? 1 : 0);
      ev_ack = (k == 0) ? 100000 : keff;
      ev_ab  = (a == 0) ? 100000 : a;
      if (ev_ab <= ev_ack && ev_ab <= TO) begin
         kind = 2; fin = a; kname = "aborted";
      end else if (ev_ack <= TO) begin
         kind = 0; fin = keff; kname = "acked";
      end else begin
         kind = 1; fin = TO; kname = "timeout";
      end
      check_outs("issue", 1, 1, 0, 0, 0);
      m_pending = 1'b1;
      for (int j = 1; j <= fin; j++) begin
         abort_i     = (kind == 2 && j == fin);
         reg_ack_i   = (k != 0 && j >= k && !(kind == 2 && j == fin));
         reg_rdata_i = reg_ack_i ? ad : 8'($urandom);
         req_valid_i = 1'($urandom_range(0, 1));
         req_write_i = 1'($urandom_range(0, 1));
         req_addr_i  = 16'($urandom) & 16'h0FFF;
         req_wdata_i = 8'($urandom);
         tick();
         if (j < fin) begin
            check_outs("wait", 1, 0, 0, 0, 0);
         end else if (kind == 0) begin
            m_pending = 1'b0;
            m_rdata   = we ? 8'h00 : ad;
            check_outs("resp", 1, 0, 1, 0, 0);
         end else if (kind == 1) begin
            if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
            check_outs("resp_to", 1, 0, 1, 1, 0);
         end else begin
            check_outs("abort", 0, 0, 0, 0, 0);
         end
      end
      abort_i   = 1'b0;
      reg_ack_i = 1'b0;
      if (kind != 2) begin
         // Request raised while in RESP must be ignored.
         req_valid_i = 1'($urandom_range(0, 1));
         req_addr_i  = 16'($urandom) & 16'h0FFF;
         tick();
         check_outs("post", 0, 0, 0, 0, 0);
      end
      req_valid_i = 1'b0;
      $display("txn %0d we=%0b addr=%04h ack_edge=%0d abort_edge=%0d stale=%0b -> %s at E%0d",
               n_txn, we, addr, k, a, stale, kname, fin);
   endtask

   initial begin
      bit          w;
      logic [15:0] ad;
      int          kk;
      int          aa;
      int          sel;
      lreset      = 1'b0;
      abort_i     = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = 16'h0000;
      req_wdata_i = 8'h00;
      reg_ack_i   = 1'b0;
      reg_rdata_i = 8'h00;
      tick();
      tick();
      check_outs("reset", 0, 0, 0, 0, 0);
      #2 lreset = 1'b1;
      idle(2, -1);

      // Read with ack at the 2nd WAIT edge
      run_txn(1'b0, 16'h0F00, 8'h00, 3, 8'hA5, 0);
      // Write acked during ISSUE
      run_txn(1'b1, 16'h0024, 8'h3C, 1, 8'h77, 0);
      // Locality 5 is above LOC_MAX
      run_txn(1'b0, 16'h5000, 8'h00, 0, 8'h00, 0);
      // Locality 4 is the highest claimed
      run_txn(1'b0, 16'h4010, 8'h00, 2, 8'h4C, 0);
      // No ack: timeout
      run_txn(1'b0, 16'h1234, 8'h00, 0, 8'h00, 0);
      idle(1, 0);
      // Ack on exactly the timeout edge
      run_txn(1'b0, 16'h0F04, 8'h00, TO, 8'h5A, 0);
      // Abort at the 3rd WAIT edge, stale ack two cycles later, new read
      run_txn(1'b0, 16'h0F08, 8'h00, 0, 8'h00, 4);
      idle(3, 1);
      run_txn(1'b0, 16'h0F0C, 8'h00, 2, 8'h11, 0);
      // Abort with no stale ack in between: next access drops its first ack
      run_txn(1'b0, 16'h0F10, 8'h00, 0, 8'h00, 2);
      run_txn(1'b0, 16'h0F14, 8'h00, 2, 8'h22, 0);

      // Reset in the middle of WAIT
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 16'h0F18;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();
      #2 lreset = 1'b0;
      #1;
      m_rdata = 8'h00; m_errcnt = 8'h00; m_addr = 16'h0000;
      m_we = 1'b0; m_wdata = 8'h00; m_pending = 1'b0;
      check_outs("midreset", 0, 0, 0, 0, 0);
      tick();
      #2 lreset = 1'b1;
      $display("txn reset asserted during WAIT");
      idle(1, -1);
      run_txn(1'b0, 16'h0F1C, 8'h00, 2, 8'h96, 0);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         w   = 1'($urandom_range(0, 1));
         ad  = {4'($urandom_range(0, 7)), 12'($urandom)};
         sel = $urandom_range(0, 3);
         kk  = (sel == 0) ? 0 :
               (sel == 1) ? $urandom_range(1, 10) :
               (sel == 2) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(1, 3);
         aa  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
         run_txn(w, ad, 8'($urandom), kk, 8'($urandom), aa);
         if ($urandom_range(0, 1) == 1)
            idle($urandom_range(1, 3), ($urandom_range(0, 2) == 0) ? 0 : -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
